regfile_mp: RTL

Parametrised multi-port register file for the pipelined core. It is the next generation of the single-write, two-read register bank. It adds configurable width, depth and port counts, optional write-to-read bypass, and a per-register pending scoreboard for long-latency producers. It also replaces simulation-print tracing with a registered commit-trace output that the testbench consumes. It sits between decode (reads, scoreboard set) and writeback (writes).

---
 rtl/regfile_pkg.sv | 16 +
 rtl/regfile_scoreboard.sv | 42 ++++
 rtl/regfile_mp.sv | 70 +++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizing helper, register/trace types and the zero-register address
package regfile_pkg;
  function automatic int aw(input int n);
    return $clog2(n);
  endfunction
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NUM_REGS = 32;
  typedef logic [aw(DEF_NUM_REGS)-1:0] reg_addr_t;
  typedef logic [DEF_DATA_W-1:0] reg_data_t;
  typedef struct packed {
    logic [31:0] pc;
    reg_addr_t   addr;
    reg_data_t   data;
  } trace_rec_t;
  localparam reg_addr_t ZERO_ADDR = '0;
endpackage

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: per-register pending bits with set-over-clear priority and bypassed lookup
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = aw(NUM_REGS)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     sb_set_en,
  input  logic [AW-1:0]            sb_set_addr,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR-1:0][AW-1:0] wr_addr,
  input  logic [NUM_RD-1:0][AW-1:0] rd_addr,
  output logic [NUM_RD-1:0]        rd_pending
);
  logic [NUM_REGS-1:0] pend, pend_nxt;
  logic [NUM_RD-1:0] hit;
  // a new producer supersedes a completing one, so set is applied after clear
  always_comb begin
    pend_nxt = pend;
    for (int k = 0; k < NUM_WR; k++)
      if (we[k]) pend_nxt[wr_addr[k]] = 1'b0;
    if (sb_set_en && !(ZERO_REG != 0 && sb_set_addr == AW'(ZERO_ADDR))) pend_nxt[sb_set_addr] = 1'b1;
  end
  always_ff @(posedge clock)
    pend <= reset ? '0 : pend_nxt;
  always_comb begin
    hit = '0;
    rd_pending = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      for (int k = 0; k < NUM_WR; k++)
        hit[j] = hit[j] | (we[k] && wr_addr[k] == rd_addr[j]);
      rd_pending[j] = pend[rd_addr[j]] && !(BYPASS != 0 && hit[j])
                      && !(ZERO_REG != 0 && rd_addr[j] == AW'(ZERO_ADDR));
    end
  end
endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file with optional bypass, pending scoreboard and commit trace
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int BYPASS = 1,
  parameter int ZERO_REG = 1,
  localparam int AW = aw(NUM_REGS)
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [NUM_RD-1:0][AW-1:0]     rd_addr,
  output logic [NUM_RD-1:0][DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]            rd_pending,
  input  logic [NUM_WR-1:0]            wr_en,
  input  logic [NUM_WR-1:0][AW-1:0]     wr_addr,
  input  logic [NUM_WR-1:0][DATA_W-1:0] wr_data,
  input  logic [NUM_WR-1:0][31:0]       wr_pc,
  input  logic                         sb_set_en,
  input  logic [AW-1:0]                sb_set_addr,
  output logic [NUM_WR-1:0]            trace_valid,
  output logic [NUM_WR-1:0][31:0]       trace_pc,
  output logic [NUM_WR-1:0][AW-1:0]     trace_addr,
  output logic [NUM_WR-1:0][DATA_W-1:0] trace_data
);
  logic [DATA_W-1:0] mem [NUM_REGS];
  logic [NUM_WR-1:0] we;
  // effective write: zero-register writes vanish entirely, including their trace
  always_comb begin
    we = '0;
    for (int k = 0; k < NUM_WR; k++)
      we[k] = wr_en[k] && !(ZERO_REG != 0 && wr_addr[k] == AW'(ZERO_ADDR));
  end
  always_ff @(posedge clock)
    if (reset) for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
    else for (int k = 0; k < NUM_WR; k++) if (we[k]) mem[wr_addr[k]] <= wr_data[k];
  always_comb begin
    rd_data = '0;
    for (int j = 0; j < NUM_RD; j++) begin
      rd_data[j] = mem[rd_addr[j]];
      for (int k = 0; k < NUM_WR; k++)
        if (BYPASS != 0 && we[k] && wr_addr[k] == rd_addr[j]) rd_data[j] = wr_data[k];
      if (ZERO_REG != 0 && rd_addr[j] == AW'(ZERO_ADDR)) rd_data[j] = '0;
    end
  end
  always_ff @(posedge clock)
    if (reset) begin
      trace_valid <= '0;
      trace_pc <= '0;
      trace_addr <= '0;
      trace_data <= '0;
    end else begin
      trace_valid <= we;
      for (int k = 0; k < NUM_WR; k++)
        if (we[k]) begin
          trace_pc[k] <= wr_pc[k];
          trace_addr[k] <= wr_addr[k];
          trace_data[k] <= wr_data[k];
        end
    end
  regfile_scoreboard #(
    .NUM_REGS(NUM_REGS), .NUM_RD(NUM_RD), .NUM_WR(NUM_WR), .BYPASS(BYPASS), .ZERO_REG(ZERO_REG)
  ) u_sb (
    .clock(clock), .reset(reset), .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr),
    .we(we), .wr_addr(wr_addr), .rd_addr(rd_addr), .rd_pending(rd_pending)
  );
endmodule
